// File: rtl/flappy_pipe_referee.sv
// Pipe referee: scrolls one pipe, randomises its gap, detects collisions, keeps score.
// Define SCORE_BCD_EN for a packed-BCD score (saturates at 8'h99); otherwise binary (saturates at 255).
module flappy_pipe_referee #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 600,
  parameter int PIPE_W     = 60,
  parameter int GAP_H      = 160,
  parameter int GAP_MIN    = 100,
  parameter int BIRD_SIZE  = 20,
  parameter int PIPE_SPEED = 2,
  parameter int SCROLL_DIV = 500000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [9:0] YBird,
  input  logic [9:0] XBird,
  output logic [9:0] XPipe,
  output logic [9:0] GapBot,
  output logic [7:0] Score,
  output logic       Lost,
  output logic       Running
);

  localparam int TW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCROLL_DIV - 1);

  localparam logic [10:0] SH11   = 11'(SCREEN_H);
  localparam logic [10:0] PW11   = 11'(PIPE_W);
  localparam logic [10:0] GH11   = 11'(GAP_H);
  localparam logic [10:0] GMIN11 = 11'(GAP_MIN);
  localparam logic [10:0] BS11   = 11'(BIRD_SIZE);
  localparam logic [10:0] SPD11  = 11'(PIPE_SPEED);
  localparam logic [9:0]  SPD10  = 10'(PIPE_SPEED);
  localparam logic [9:0]  X_RESET   = 10'(SCREEN_W);
  localparam logic [9:0]  GAP_RESET = 10'(GAP_MIN + 100);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_LOST = 3'b100
  } state_t;

  state_t state, state_next;

  logic [TW-1:0] tick;
  logic          scored;
  logic [7:0]    lfsr;
  logic          lfsr_fb;

  logic [10:0] xb, yb, xp, gb;
  logic        floor_hit, ceil_hit, x_overlap, y_outside, collision;
  logic        pass_now, tick_wrap;
  logic [10:0] gap_new;

  // All geometry done at 11 bits so sums like XPipe+PIPE_W never overflow.
  always_comb begin
    xb = {1'b0, XBird};
    yb = {1'b0, YBird};
    xp = {1'b0, XPipe};
    gb = {1'b0, GapBot};
    floor_hit = (YBird == 10'd0);
    ceil_hit  = (yb + BS11) > SH11;
    x_overlap = ((xb + BS11) > xp) && (xb < (xp + PW11));
    y_outside = (yb < gb) || ((yb + BS11) > (gb + GH11));
    collision = floor_hit || ceil_hit || (x_overlap && y_outside);
    pass_now  = !scored && ((xp + PW11) < xb);
    tick_wrap = (tick == TICK_LAST);
    gap_new   = GMIN11 + {3'b000, lfsr};
    lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (Start) state_next = S_RUN;
      S_RUN:   if (collision) state_next = S_LOST;
      S_LOST:  if (Start) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    Running = (state == S_RUN);
    Lost    = (state == S_LOST);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      XPipe  <= X_RESET;
      GapBot <= GAP_RESET;
      Score  <= 8'd0;
      tick   <= '0;
      scored <= 1'b0;
      lfsr   <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
      // Entering or sitting in IDLE restores the start-of-run playfield.
      if (state_next == S_IDLE) begin
        XPipe  <= X_RESET;
        GapBot <= GAP_RESET;
        Score  <= 8'd0;
        tick   <= '0;
        scored <= 1'b0;
      end else if (state == S_RUN && !collision) begin
        if (pass_now) begin
          scored <= 1'b1;
`ifdef SCORE_BCD_EN
          if (Score != 8'h99) begin
            if (Score[3:0] == 4'd9) Score <= {Score[7:4] + 4'd1, 4'd0};
            else                    Score <= Score + 8'd1;
          end
`else
          if (Score != 8'hFF) Score <= Score + 8'd1;
`endif
        end
        // A respawn's scored clear deliberately overrides a same-cycle score.
        if (tick_wrap) begin
          tick <= '0;
          if (xp <= SPD11) begin
            XPipe  <= X_RESET;
            GapBot <= gap_new[9:0];
            scored <= 1'b0;
          end else begin
            XPipe <= XPipe - SPD10;
          end
        end else begin
          tick <= tick + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_flappy_pipe_referee.sv
// Self-checking bench for flappy_pipe_referee: scrolling, scoring, collisions and score saturation.
module tb_flappy_pipe_referee;

  logic       Clk = 1'b0;
  logic       Reset, Start;
  logic [9:0] YBird, XBird;
  logic [9:0] XPipe, GapBot;
  logic [7:0] Score;
  logic       Lost, Running;

  logic       sat_start;
  logic [9:0] sat_ybird, sat_xbird;
  logic [9:0] sat_xpipe, sat_gapbot;
  logic [7:0] sat_score;
  logic       sat_lost, sat_running;

  int n_cmp = 0;
  int n_err = 0;

  // {gap_any, xpipe, gapbot, score, lost, running}
  logic [30:0] exp_q[$];
  logic [7:0]  score_q[$];

  always #5 Clk = ~Clk;

  flappy_pipe_referee #(.SCROLL_DIV(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .YBird(YBird), .XBird(XBird),
    .XPipe(XPipe), .GapBot(GapBot), .Score(Score), .Lost(Lost), .Running(Running)
  );

  flappy_pipe_referee #(.SCROLL_DIV(1), .PIPE_SPEED(200)) sat_dut (
    .Clk(Clk), .Reset(Reset), .Start(sat_start), .YBird(sat_ybird), .XBird(sat_xbird),
    .XPipe(sat_xpipe), .GapBot(sat_gapbot), .Score(sat_score), .Lost(sat_lost),
    .Running(sat_running)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_exp(input logic gap_any, input logic [9:0] xp, input logic [9:0] gb,
                          input logic [7:0] sc, input logic lo, input logic ru);
    exp_q.push_back({gap_any, xp, gb, sc, lo, ru});
  endtask

  task automatic compare_main(input string tag);
    logic [30:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, ".queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq({tag, ".xpipe"}, 32'(XPipe), 32'(e[29:20]));
    if (e[30]) check_eq({tag, ".gap_range"}, 32'(GapBot >= 10'd100 && GapBot <= 10'd355), 32'd1);
    else       check_eq({tag, ".gapbot"}, 32'(GapBot), 32'(e[19:10]));
    check_eq({tag, ".score"}, 32'(Score), 32'(e[9:2]));
    check_eq({tag, ".lost"}, 32'(Lost), 32'(e[1]));
    check_eq({tag, ".running"}, 32'(Running), 32'(e[0]));
  endtask

  task automatic wait_xpipe(input logic [9:0] target, input int budget);
    int n = 0;
    while (XPipe != target && n < budget) begin
      step();
      n++;
    end
    check_eq("wait_xpipe", 32'(XPipe), 32'(target));
  endtask

  function automatic logic [7:0] sat_expect(input int p);
    int q;
`ifdef SCORE_BCD_EN
    q = (p > 99) ? 99 : p;
    return {4'(q / 10), 4'(q % 10)};
`else
    q = (p > 255) ? 255 : p;
    return 8'(q);
`endif
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b1; Start = 1'b0; XBird = 10'd100; YBird = 10'd300;
    sat_start = 1'b0; sat_xbird = 10'd1000; sat_ybird = 10'd300;
    repeat (3) step();
    push_exp(0, 10'd640, 10'd200, 8'd0, 0, 0); compare_main("reset");
    check_eq("sat_reset.score", 32'(sat_score), 32'd0);
    Reset = 1'b0;
    repeat (20) step();
    push_exp(0, 10'd640, 10'd200, 8'd0, 0, 0); compare_main("idle20");

    // scroll cadence
    Start = 1'b1; step(); Start = 1'b0;
    push_exp(0, 10'd640, 10'd200, 8'd0, 0, 1); compare_main("run_entry");
    repeat (3) step();
    push_exp(0, 10'd640, 10'd200, 8'd0, 0, 1); compare_main("pre_tick");
    step();
    push_exp(0, 10'd638, 10'd200, 8'd0, 0, 1); compare_main("tick1");
    repeat (4) step();
    push_exp(0, 10'd636, 10'd200, 8'd0, 0, 1); compare_main("tick2");

    // score exactly once as the pipe clears the bird
    wait_xpipe(10'd40, 2000);
    push_exp(0, 10'd40, 10'd200, 8'd0, 0, 1); compare_main("x40");
    wait_xpipe(10'd38, 10);
    push_exp(0, 10'd38, 10'd200, 8'd0, 0, 1); compare_main("x38");
    step();
    push_exp(0, 10'd38, 10'd200, 8'd1, 0, 1); compare_main("scored");
    wait_xpipe(10'd2, 2000);
    push_exp(0, 10'd2, 10'd200, 8'd1, 0, 1); compare_main("x2");
    n = 0;
    while (XPipe != 10'd640 && n < 10) begin
      step();
      n++;
    end
    check_eq("respawn_latency", 32'(n), 32'd4);
    push_exp(1, 10'd640, 10'd0, 8'd1, 0, 1); compare_main("respawn");

    // floor
    YBird = 10'd0; step();
    push_exp(1, 10'd640, 10'd0, 8'd1, 1, 0); compare_main("floor");
    YBird = 10'd300;
    Start = 1'b1; step(); Start = 1'b0;
    push_exp(0, 10'd640, 10'd200, 8'd0, 0, 0); compare_main("lost_to_idle");
    Start = 1'b1; step(); Start = 1'b0;
    push_exp(0, 10'd640, 10'd200, 8'd0, 0, 1); compare_main("run_entry2");

    // pipe body hit, then frozen
    wait_xpipe(10'd110, 2000);
    YBird = 10'd150; step();
    push_exp(0, 10'd110, 10'd200, 8'd0, 1, 0); compare_main("pipe_hit");
    repeat (50) step();
    push_exp(0, 10'd110, 10'd200, 8'd0, 1, 0); compare_main("frozen50");

    // Start held: LOST -> IDLE -> RUN
    YBird = 10'd300; Start = 1'b1; step();
    push_exp(0, 10'd640, 10'd200, 8'd0, 0, 0); compare_main("held_idle");
    step(); Start = 1'b0;
    push_exp(0, 10'd640, 10'd200, 8'd0, 0, 1); compare_main("held_run");

    // ceiling boundary
    YBird = 10'd581; step();
    push_exp(0, 10'd640, 10'd200, 8'd0, 1, 0); compare_main("ceiling");
    YBird = 10'd580; Start = 1'b1; step(); step(); Start = 1'b0;
    push_exp(0, 10'd640, 10'd200, 8'd0, 0, 1); compare_main("restart");
    repeat (12) step();
    push_exp(0, 10'd634, 10'd200, 8'd0, 0, 1); compare_main("ceil_ok");

    // reset mid-run
    Reset = 1'b1; step(); Reset = 1'b0;
    push_exp(0, 10'd640, 10'd200, 8'd0, 0, 0); compare_main("mid_reset");

    // saturation on the fast-scrolling instance: one pass every 4 cycles
    sat_start = 1'b1; step(); sat_start = 1'b0;
    for (int p = 1; p <= 300; p++) begin
      if (p == 1) step();
      else repeat (4) step();
      score_q.push_back(sat_expect(p));
      if (score_q.size() != 0) check_eq($sformatf("sat_pass%0d", p), 32'(sat_score), 32'(score_q.pop_front()));
    end
    check_eq("sat_still_running", 32'(sat_running), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
